// File: rtl/banking_mmu.sv
// C64 CPU-side MMU: 6510 processor port with bit 6/7 fade, configuration register
// with preset/load-trigger slots, and CPU address decode into one-hot chip selects.
module banking_mmu #(
  parameter logic [15:0] CFG_ADDR    = 16'hFF00,
  parameter int          NPRE        = 4,
  parameter int          BANK_BITS   = 2,
  parameter int          FADE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 _RESET,
  input  logic                 phi2_en,
  input  logic [15:0]          A,
  input  logic [7:0]           DI,
  input  logic                 R__W,
  input  logic                 _AEC,
  input  logic                 _GAME,
  input  logic                 _EXROM,
  input  logic [7:0]           PIN_IN,
  output logic [7:0]           DO,
  output logic                 DO_EN,
  output logic [7:0]           PORT_OUT,
  output logic [7:0]           PORT_OE,
  output logic [BANK_BITS-1:0] RAM_BANK,
  output logic                 RAM,
  output logic                 BASIC,
  output logic                 KERNAL,
  output logic                 CHAROM,
  output logic                 IO,
  output logic                 ROML,
  output logic                 ROMH
);

  localparam int CR_W = 4 + BANK_BITS;
  localparam int FC_W = $clog2(FADE_CYCLES + 1);
  localparam logic [FC_W-1:0] FADE_LOAD = FC_W'(FADE_CYCLES);

  logic [7:0]      ddr;
  logic [7:0]      data;
  logic [CR_W-1:0] cr;
  logic [CR_W-1:0] presets [NPRE];
  logic [FC_W-1:0] fade_cnt [2];

  logic            wr;
  logic            rd;
  logic            is_ddr;
  logic            is_data;
  logic [15:0]     cfg_off;
  logic            cfg_hit;
  logic            is_cr;
  logic            is_pre;
  logic            is_trig;
  logic [15:0]     sel_off;
  logic [CR_W-1:0] sel_pre;
  logic [1:0]      fade;
  logic [7:0]      port_rd;
  logic            c_bit;
  logic            h_bit;
  logic            l_bit;
  logic            ultimax;

  assign wr      = phi2_en && !R__W && !_AEC;
  assign rd      = R__W && !_AEC;
  assign is_ddr  = (A == 16'h0000);
  assign is_data = (A == 16'h0001);

  // Config space is CR, then NPRE presets, then NPRE load triggers (both 1-based).
  assign cfg_off = A - CFG_ADDR;
  assign cfg_hit = (A >= CFG_ADDR) && (cfg_off <= 16'(2 * NPRE));
  assign is_cr   = cfg_hit && (cfg_off == 16'd0);
  assign is_pre  = cfg_hit && (cfg_off != 16'd0) && (cfg_off <= 16'(NPRE));
  assign is_trig = cfg_hit && (cfg_off > 16'(NPRE));
  assign sel_off = is_pre ? (cfg_off - 16'd1) : (cfg_off - 16'(NPRE + 1));

  always_comb begin
    sel_pre = '0;
    for (int p = 0; p < NPRE; p++) begin
      if (sel_off == 16'(p)) sel_pre = presets[p];
    end
  end

  assign fade     = {fade_cnt[1] != '0, fade_cnt[0] != '0};
  assign PORT_OUT = data | ~ddr;
  assign PORT_OE  = ddr;
  assign port_rd  = (ddr & data) | (~ddr & {fade, PIN_IN[5:0]});
  assign RAM_BANK = cr[3+BANK_BITS:4];

  assign {c_bit, h_bit, l_bit} = cr[3] ? cr[2:0] : PORT_OUT[2:0];
  assign ultimax = !_GAME && _EXROM;

  always_ff @(posedge clk) begin
    if (!_RESET) begin
      ddr  <= '0;
      data <= '0;
      cr   <= '0;
      for (int p = 0; p < NPRE; p++) presets[p] <= '0;
      for (int b = 0; b < 2; b++) fade_cnt[b] <= '0;
    end else begin
      if (wr && is_ddr)  ddr  <= DI;
      if (wr && is_data) data <= DI;
      if (wr && is_cr)   cr   <= DI[CR_W-1:0];
      if (wr && is_trig) cr   <= sel_pre;
      for (int p = 0; p < NPRE; p++) begin
        if (wr && is_pre && (sel_off == 16'(p))) presets[p] <= DI[CR_W-1:0];
      end
      // A driven-high output bit that turns into an input keeps reading 1 for a while.
      for (int b = 0; b < 2; b++) begin
        if (wr && is_ddr && DI[6+b])
          fade_cnt[b] <= '0;
        else if (wr && is_ddr && ddr[6+b] && data[6+b])
          fade_cnt[b] <= FADE_LOAD;
        else if (phi2_en && (fade_cnt[b] != '0))
          fade_cnt[b] <= fade_cnt[b] - 1'b1;
      end
    end
  end

  always_comb begin
    DO    = '0;
    DO_EN = 1'b0;
    if (rd) begin
      if (is_ddr) begin
        DO    = ddr;
        DO_EN = 1'b1;
      end else if (is_data) begin
        DO    = port_rd;
        DO_EN = 1'b1;
      end else if (cfg_hit) begin
        DO    = is_pre ? 8'(sel_pre) : 8'(cr);
        DO_EN = 1'b1;
      end
    end
  end

  // Priority: port registers, config space, Ultimax, then normal banking.
  always_comb begin
    RAM    = 1'b0;
    BASIC  = 1'b0;
    KERNAL = 1'b0;
    CHAROM = 1'b0;
    IO     = 1'b0;
    ROML   = 1'b0;
    ROMH   = 1'b0;
    if (!_AEC) begin
      if (is_ddr || is_data) begin
        RAM = !R__W;
      end else if (cfg_hit) begin
        RAM = 1'b0;
      end else if (ultimax) begin
        if (A[15:12] == 4'h0)            RAM  = 1'b1;
        else if (A[15:13] == 3'b100)     ROML = 1'b1;
        else if (A[15:12] == 4'hD)       IO   = 1'b1;
        else if ((A[15:13] == 3'b111) && R__W) ROMH = 1'b1;
      end else if ((A[15:13] == 3'b101) && R__W && l_bit && h_bit) begin
        if (_GAME)        BASIC = 1'b1;
        else if (!_EXROM) ROMH  = 1'b1;
        else              RAM   = 1'b1;
      end else if ((A[15:13] == 3'b111) && R__W && h_bit) begin
        KERNAL = 1'b1;
      end else if ((A[15:12] == 4'hD) && (h_bit || l_bit)) begin
        if (c_bit)     IO     = 1'b1;
        else if (R__W) CHAROM = 1'b1;
        else           RAM    = 1'b1;
      end else if ((A[15:13] == 3'b100) && R__W && l_bit && h_bit && !_EXROM) begin
        ROML = 1'b1;
      end else begin
        RAM = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_banking_mmu.sv
// Directed testbench for banking_mmu: port registers, fade, config presets,
// cartridge/Ultimax decode and reset behaviour with hand-computed expectations.
module tb_banking_mmu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        phi2_en;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        r_w;
  logic        aec_n;
  logic        game_n;
  logic        exrom_n;
  logic [7:0]  pin_in;
  logic [7:0]  dout;
  logic        do_en;
  logic [7:0]  port_out;
  logic [7:0]  port_oe;
  logic [1:0]  ram_bank;
  logic        ram, basic, kernal, charom, io, roml, romh;
  logic [6:0]  sels;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [6:0] S_NONE   = 7'b0000000;
  localparam logic [6:0] S_RAM    = 7'b1000000;
  localparam logic [6:0] S_BASIC  = 7'b0100000;
  localparam logic [6:0] S_KERNAL = 7'b0010000;
  localparam logic [6:0] S_CHAROM = 7'b0001000;
  localparam logic [6:0] S_IO     = 7'b0000100;
  localparam logic [6:0] S_ROML   = 7'b0000010;
  localparam logic [6:0] S_ROMH   = 7'b0000001;

  banking_mmu dut (
    .clk      (clk),
    ._RESET   (reset_n),
    .phi2_en  (phi2_en),
    .A        (addr),
    .DI       (din),
    .R__W     (r_w),
    ._AEC     (aec_n),
    ._GAME    (game_n),
    ._EXROM   (exrom_n),
    .PIN_IN   (pin_in),
    .DO       (dout),
    .DO_EN    (do_en),
    .PORT_OUT (port_out),
    .PORT_OE  (port_oe),
    .RAM_BANK (ram_bank),
    .RAM      (ram),
    .BASIC    (basic),
    .KERNAL   (kernal),
    .CHAROM   (charom),
    .IO       (io),
    .ROML     (roml),
    .ROMH     (romh)
  );

  assign sels = {ram, basic, kernal, charom, io, roml, romh};

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drives one bus cycle mid-period so outputs settle before the committing edge.
  task automatic applyStimulus(input logic [15:0] a, input logic rw, input logic [7:0] d,
                               input logic strobe);
    @(negedge clk);
    addr    = a;
    r_w     = rw;
    din     = d;
    phi2_en = strobe;
    #1;
  endtask

  task automatic finishCycle();
    @(posedge clk);
    #1;
    phi2_en = 1'b0;
    r_w     = 1'b1;
  endtask

  task automatic writeReg(input logic [15:0] a, input logic [7:0] d);
    applyStimulus(a, 1'b0, d, 1'b1);
    finishCycle();
  endtask

  task automatic writeCheck(input string tag, input logic [15:0] a, input logic [7:0] d,
                            input logic [6:0] exp_sel);
    applyStimulus(a, 1'b0, d, 1'b1);
    checkOutput({tag, "_sel"}, 16'(sels), 16'(exp_sel));
    finishCycle();
  endtask

  task automatic readCheck(input string tag, input logic [15:0] a, input logic [7:0] exp_do,
                           input logic exp_en, input logic [6:0] exp_sel);
    applyStimulus(a, 1'b1, 8'h00, 1'b1);
    checkOutput({tag, "_sel"}, 16'(sels), 16'(exp_sel));
    checkOutput({tag, "_en"}, 16'(do_en), 16'(exp_en));
    if (exp_en) checkOutput({tag, "_do"}, 16'(dout), 16'(exp_do));
    finishCycle();
  endtask

  // Reset while a write strobe to $0000 is pending: reset must win.
  task automatic applyReset();
    @(negedge clk);
    reset_n = 1'b0;
    addr    = 16'h0000;
    din     = 8'hFF;
    r_w     = 1'b0;
    phi2_en = 1'b1;
    @(posedge clk);
    #1;
    phi2_en = 1'b0;
    r_w     = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    phi2_en = 1'b0;
    addr    = 16'h0000;
    din     = 8'h00;
    r_w     = 1'b1;
    aec_n   = 1'b1;
    game_n  = 1'b1;
    exrom_n = 1'b1;
    pin_in  = 8'h00;
    applyReset();
    addr = 16'h0000;
    #1;
    checkOutput("rst_do", 16'(dout), 16'h00);
    checkOutput("rst_do_en", 16'(do_en), 16'h0);
    checkOutput("rst_sel", 16'(sels), 16'(S_NONE));
    checkOutput("rst_port_out", 16'(port_out), 16'hFF);
    checkOutput("rst_port_oe", 16'(port_oe), 16'h00);
    checkOutput("rst_bank", 16'(ram_bank), 16'h0);

    aec_n = 1'b0;
    readCheck("rd_basic", 16'hA000, 8'h00, 1'b0, S_BASIC);
    readCheck("rd_kernal", 16'hE000, 8'h00, 1'b0, S_KERNAL);
    readCheck("rd_io", 16'hD000, 8'h00, 1'b0, S_IO);
    readCheck("rd_ram", 16'h4000, 8'h00, 1'b0, S_RAM);
    readCheck("rd_port1_rst", 16'h0001, 8'h00, 1'b1, S_NONE);
    readCheck("rd_port0_rst", 16'h0000, 8'h00, 1'b1, S_NONE);

    writeCheck("wr_ddr07", 16'h0000, 8'h07, S_RAM);
    writeCheck("wr_data05", 16'h0001, 8'h05, S_RAM);
    checkOutput("port_out_fd", 16'(port_out), 16'hFD);
    checkOutput("port_oe_07", 16'(port_oe), 16'h07);
    readCheck("h0_a000", 16'hA000, 8'h00, 1'b0, S_RAM);
    readCheck("h0_e000", 16'hE000, 8'h00, 1'b0, S_RAM);
    readCheck("h0_d000", 16'hD000, 8'h00, 1'b0, S_IO);
    writeReg(16'h0001, 8'h04);
    readCheck("lh0_d000", 16'hD000, 8'h00, 1'b0, S_RAM);
    pin_in = 8'hE8;
    readCheck("rd_port_mix", 16'h0001, 8'h2C, 1'b1, S_NONE);

    writeReg(16'h0000, 8'hC7);
    writeReg(16'h0001, 8'hC7);
    readCheck("rd_port_c7", 16'h0001, 8'hEF, 1'b1, S_NONE);
    writeReg(16'h0000, 8'h07);
    for (int k = 0; k < 16; k++) begin
      readCheck($sformatf("fade_hold%0d", k), 16'h0001, 8'hEF, 1'b1, S_NONE);
    end
    readCheck("fade_done", 16'h0001, 8'h2F, 1'b1, S_NONE);

    writeReg(16'h0000, 8'hC7);
    writeReg(16'h0000, 8'h07);
    for (int k = 0; k < 3; k++) begin
      readCheck($sformatf("fade_mid%0d", k), 16'h0001, 8'hEF, 1'b1, S_NONE);
    end
    writeReg(16'h0000, 8'hC7);
    writeReg(16'h0001, 8'h07);
    writeReg(16'h0000, 8'h07);
    readCheck("fade_cleared", 16'h0001, 8'h2F, 1'b1, S_NONE);

    writeReg(16'hFF02, 8'h1B);
    readCheck("rd_pre2", 16'hFF02, 8'h1B, 1'b1, S_NONE);
    readCheck("rd_cr_before", 16'hFF00, 8'h00, 1'b1, S_NONE);
    writeReg(16'hFF06, 8'h00);
    checkOutput("bank_1", 16'(ram_bank), 16'h1);
    readCheck("rd_cr_loaded", 16'hFF00, 8'h1B, 1'b1, S_NONE);
    readCheck("ovr_d000", 16'hD000, 8'h00, 1'b0, S_CHAROM);
    writeCheck("ovr_wr_d000", 16'hD000, 8'h55, S_RAM);
    readCheck("ovr_a000", 16'hA000, 8'h00, 1'b0, S_BASIC);
    writeReg(16'hFF02, 8'h05);
    readCheck("rd_trig", 16'hFF06, 8'h1B, 1'b1, S_NONE);
    readCheck("rd_cr_noreload", 16'hFF00, 8'h1B, 1'b1, S_NONE);
    writeReg(16'hFF00, 8'hFF);
    readCheck("rd_cr_mask", 16'hFF00, 8'h3F, 1'b1, S_NONE);
    checkOutput("bank_3", 16'(ram_bank), 16'h3);
    writeReg(16'hFF00, 8'h1B);

    game_n  = 1'b0;
    exrom_n = 1'b1;
    readCheck("ult_e000", 16'hE000, 8'h00, 1'b0, S_ROMH);
    readCheck("ult_4000", 16'h4000, 8'h00, 1'b0, S_NONE);
    readCheck("ult_0800", 16'h0800, 8'h00, 1'b0, S_RAM);
    readCheck("ult_8000", 16'h8000, 8'h00, 1'b0, S_ROML);
    readCheck("ult_d000", 16'hD000, 8'h00, 1'b0, S_IO);
    readCheck("ult_cfg", 16'hFF00, 8'h1B, 1'b1, S_NONE);
    exrom_n = 1'b0;
    readCheck("cart16_a000", 16'hA000, 8'h00, 1'b0, S_ROMH);
    readCheck("cart16_8000", 16'h8000, 8'h00, 1'b0, S_ROML);
    game_n = 1'b1;
    readCheck("cart8_8000", 16'h8000, 8'h00, 1'b0, S_ROML);
    readCheck("cart8_a000", 16'hA000, 8'h00, 1'b0, S_BASIC);
    exrom_n = 1'b1;
    aec_n   = 1'b1;
    readCheck("aec_high", 16'hA000, 8'h00, 1'b0, S_NONE);
    aec_n = 1'b0;

    writeReg(16'h0001, 8'hC7);
    writeReg(16'h0000, 8'hC7);
    writeReg(16'h0000, 8'h07);
    readCheck("prerst_fade", 16'h0001, 8'hEF, 1'b1, S_NONE);
    applyReset();
    #1;
    checkOutput("rst2_bank", 16'(ram_bank), 16'h0);
    checkOutput("rst2_port_out", 16'(port_out), 16'hFF);
    checkOutput("rst2_port_oe", 16'(port_oe), 16'h00);
    readCheck("rst2_port1", 16'h0001, 8'h28, 1'b1, S_NONE);
    readCheck("rst2_port0", 16'h0000, 8'h00, 1'b1, S_NONE);
    readCheck("rst2_cr", 16'hFF00, 8'h00, 1'b1, S_NONE);
    readCheck("rst2_pre2", 16'hFF02, 8'h00, 1'b1, S_NONE);
    readCheck("rst2_d000", 16'hD000, 8'h00, 1'b0, S_IO);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
